mips_instr_encoder: RTL

Instruction encoder: the producer-side counterpart to the control decoder. Accepts symbolic instructions (mnemonic code plus register, immediate and target fields) and assembles 32-bit MIPS words using the same opcode set the control decoder consumes. Words are buffered in a small FIFO and streamed to the instruction-memory loader over valid/ready, each tagged with a sequential word address. Used by the boot/program loader and by testbenches to generate instruction streams.

---
 rtl/mips_instr_encoder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mips_instr_encoder.sv
// Symbolic-to-binary MIPS instruction encoder feeding a small FIFO with word-address tagging.
// Build option: define DELAY_SLOT_NOP_EN to append a NOP word after every BEQ/BNE/J.
module mips_instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 30
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [4:0]        i_mnem,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_shamt,
  input  logic [15:0]       i_imm,
  input  logic [25:0]       i_target,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [4:0] {
    M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_XOR, M_NOR,
    M_SLL, M_SRL, M_SRA, M_ROR, M_ROL,
    M_LW, M_SW, M_BEQ, M_BNE, M_ADDI, M_SLTI, M_ANDI, M_ORI, M_XORI, M_J
  } mnem_e;

  typedef enum logic [1:0] {K_R, K_SHIFT, K_IMM, K_JUMP} fmt_e;

  logic [31:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;

  fmt_e        w_fmt;
  logic [5:0]  w_code;
  logic        w_legal;
  logic [31:0] w_word;
  logic        w_accept;
  logic        w_pop;
  logic [1:0]  w_push_n;

  // w_code holds funct for R-type formats and the opcode for I/J formats.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    w_fmt   = K_R;
    w_code  = 6'b000000;
    w_legal = 1'b1;
    case (i_mnem)
      M_ADD:  w_code = 6'b100000;
      M_SUB:  w_code = 6'b100010;
      M_AND:  w_code = 6'b100100;
      M_OR:   w_code = 6'b100101;
      M_SLT:  w_code = 6'b101010;
      M_XOR:  w_code = 6'b100110;
      M_NOR:  w_code = 6'b100111;
      M_SLL:  begin w_fmt = K_SHIFT; w_code = 6'b000000; end
      M_SRL:  begin w_fmt = K_SHIFT; w_code = 6'b000010; end
      M_SRA:  begin w_fmt = K_SHIFT; w_code = 6'b000011; end
      M_ROR:  begin w_fmt = K_SHIFT; w_code = 6'b000100; end
      M_ROL:  begin w_fmt = K_SHIFT; w_code = 6'b000101; end
      M_LW:   begin w_fmt = K_IMM;   w_code = 6'b100011; end
      M_SW:   begin w_fmt = K_IMM;   w_code = 6'b101011; end
      M_BEQ:  begin w_fmt = K_IMM;   w_code = 6'b000100; end
      M_BNE:  begin w_fmt = K_IMM;   w_code = 6'b000101; end
      M_ADDI: begin w_fmt = K_IMM;   w_code = 6'b001000; end
      M_SLTI: begin w_fmt = K_IMM;   w_code = 6'b001010; end
      M_ANDI: begin w_fmt = K_IMM;   w_code = 6'b001100; end
      M_ORI:  begin w_fmt = K_IMM;   w_code = 6'b001101; end
      M_XORI: begin w_fmt = K_IMM;   w_code = 6'b001110; end
      M_J:    begin w_fmt = K_JUMP;  w_code = 6'b000010; end
      default: w_legal = 1'b0;
    endcase

    case (w_fmt)
      K_R:     w_word = {6'b000000, i_rs, i_rt, i_rd, 5'b00000, w_code};
      K_SHIFT: w_word = {6'b000000, 5'b00000, i_rt, i_rd, i_shamt, w_code};
      K_IMM:   w_word = {w_code, i_rs, i_rt, i_imm};
      default: w_word = {w_code, i_target};
    endcase
  end

  assign w_accept = i_valid && o_ready;
  assign w_pop    = o_valid && i_ready;

`ifdef DELAY_SLOT_NOP_EN
  localparam logic [CNT_W-1:0] NEAR_FULL_CNT = CNT_W'(DEPTH - 1);

  logic             w_is_cti;
  logic [PTR_W-1:0] w_wr_ptr_nxt;

  // Branches and jumps need room for the branch word and its delay-slot NOP.
  assign w_is_cti     = i_valid && (i_mnem == M_BEQ || i_mnem == M_BNE || i_mnem == M_J);
  assign o_ready      = w_is_cti ? (r_count < NEAR_FULL_CNT) : (r_count < FULL_CNT);
  assign w_push_n     = (w_accept && w_legal) ? (w_is_cti ? 2'd2 : 2'd1) : 2'd0;
  assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
`else
  assign o_ready  = r_count < FULL_CNT;
  assign w_push_n = {1'b0, w_accept && w_legal};
`endif

  // NOTE: storage is not reset; o_valid/o_instr masking hides stale entries.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push_n != 2'd0) begin
      r_mem[r_wr_ptr] <= w_word;
`ifdef DELAY_SLOT_NOP_EN
      if (w_push_n == 2'd2) r_mem[w_wr_ptr_nxt] <= 32'h0000_0000;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= ADDR_W'(BASE_ADDR);
      r_err    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_count  <= r_count + CNT_W'(w_push_n) - CNT_W'(w_pop);
      if (w_pop) r_addr <= r_addr + ADDR_W'(1);
      if (w_accept && !w_legal) r_err <= 1'b1;
    end
  end

  assign o_valid = (r_count != '0);
  assign o_instr = o_valid ? r_mem[r_rd_ptr] : 32'h0000_0000;
  assign o_addr  = r_addr;
  assign o_err   = r_err;

endmodule
